// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: operand width and the serial-unit FSM states.
package arith_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full subtractor; the borrow-chain dual of the full adder cell.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor4bits.sv
// Bit-serial a - b through a single full-subtractor cell, LSB first, with a
// start/busy/done handshake. d = {borrow, (a - b) mod 16}.
module serial_subtractor4bits
  import arith_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   d
);

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r, acc;
  logic             borrow;
  logic [1:0]       idx;
  logic             fs_diff, fs_bout;

  fullsubtractor u_fs (
    .a    (a_r[idx]),
    .b    (b_r[idx]),
    .bin  (borrow),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= 1'b0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          acc[idx] <= fs_diff;
          borrow   <= fs_bout;
          idx      <= idx + 2'd1;
          if (idx == 2'd3) begin
            // Last bit bypasses acc so d updates in one step, never partially.
            d     <= {fs_bout, fs_diff, acc[WIDTH-2:0]};
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor4bits.sv
// Self-checking bench: directed vector table, exhaustive and random sweeps
// against an arithmetic reference, plus handshake/reset corner sequences.
module tb_serial_subtractor4bits;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic       busy, done;
  logic [4:0] d;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor4bits dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] exp;
  } vec_t;

  function automatic logic [4:0] ref_sub(input logic [3:0] x, input logic [3:0] y);
    int r;
    r = int'(x) - int'(y);
    return r[4:0];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge, unit idle.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input logic [4:0] exp,
                        input string nm);
    logic [4:0] prev;
    int n;
    prev  = d;
    a     = ta;
    b     = tb_;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 4'($urandom);
    b     = 4'($urandom);
    n     = 0;
    while (!done && n < 12) begin
      if (busy) n++;
      chk({nm, " d stable"}, int'(d), int'(prev));
      @(negedge clk);
    end
    chk({nm, " done"}, int'(done), 1);
    chk({nm, " busy cycles"}, n, 4);
    chk({nm, " overlap"}, int'(busy & done), 0);
    chk({nm, " d"}, int'(d), int'(exp));
    @(negedge clk);
    chk({nm, " done pulse"}, int'(done), 0);
    chk({nm, " idle busy"}, int'(busy), 0);
  endtask

  initial begin
    vec_t vt[4];
    int   done_cnt, last_done, gap_bad, ovl;

    vt[0] = '{4'd9,  4'd3,  5'b00110};
    vt[1] = '{4'd3,  4'd9,  5'b11010};
    vt[2] = '{4'd0,  4'd15, 5'b10001};
    vt[3] = '{4'd15, 4'd15, 5'b00000};

    // Reset state
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset d", int'(d), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vt[i]) run_op(vt[i].a, vt[i].b, vt[i].exp, "vector");

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run_op(4'(x), 4'(y), ref_sub(4'(x), 4'(y)), "sweep");

    for (int k = 0; k < 20; k++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom);
      rb = 4'($urandom);
      run_op(ra, rb, ref_sub(ra, rb), "random");
    end

    // Operand changes and start pulse mid-operation are ignored
    a = 4'd7; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd0; b = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        done_cnt++;
        chk("midshift d", int'(d), 5'b00101);
      end
      chk("midshift overlap", int'(busy & done), 0);
      @(negedge clk);
    end
    chk("midshift done count", done_cnt, 1);
    chk("midshift no extra op", int'(busy), 0);

    // start held continuously
    a = 4'd5; b = 4'd6; start = 1'b1;
    done_cnt = 0; last_done = -1; gap_bad = 0; ovl = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (busy && done) ovl++;
      if (done) begin
        chk("stream d", int'(d), 5'b11111);
        if (last_done >= 0 && i - last_done != 5) gap_bad++;
        last_done = i;
        done_cnt++;
      end
    end
    start = 1'b0;
    chk("stream done count", done_cnt, 5);
    chk("stream spacing", gap_bad, 0);
    chk("stream overlap", ovl, 0);
    @(negedge clk);
    @(negedge clk);

    // Reset mid-operation
    a = 4'd8; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort d", int'(d), 0);
    @(negedge clk);
    chk("abort no done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    run_op(4'd8, 4'd1, 5'b00111, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
